// File: rtl/aquatux_spi_pkg.sv
// Shared types and helpers for the AquaTux SPI responder.
// Contents: default frame width, FSM state enum, and the helper that maps
// CPOL/CPHA plus the raw SCLK edges onto sample/shift strobes.
package aquatux_spi_pkg;

  localparam int unsigned SPI_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE
  } spi_state_e;

  typedef struct packed {
    logic sample;
    logic shift;
  } spi_edge_t;

  // Leading edge is rise for CPOL=0 and fall for CPOL=1. CPHA picks which
  // of leading/trailing samples MOSI; the other one shifts MISO.
  function automatic spi_edge_t spi_edge_sel(input logic cpol, input logic cpha,
                                             input logic rise, input logic fall);
    logic      leading;
    logic      trailing;
    spi_edge_t e;
    leading  = cpol ? fall : rise;
    trailing = cpol ? rise : fall;
    e.sample = cpha ? trailing : leading;
    e.shift  = cpha ? leading : trailing;
    return e;
  endfunction

endpackage

// File: rtl/aquatux_spi_slave_sync2.sv
// Two-flop synchronizer for one asynchronous bus input.
// Ports: clk/reset (sync, active-high), d = async input, q = synced output.
// RESET_VAL sets the value both flops take during reset.
module spi_sync2
  import aquatux_spi_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/aquatux_spi_slave.sv
// SPI responder (AD7264 emulation / FPGA-as-slave).
// Oversamples SCLK/SS/MOSI on Clk, receives one WIDTH-bit command on MOSI and
// returns txA_data/txB_data MSB-first on MISOA/MISOB. CPOL/CPHA and both tx
// words are captured when SS falls.
// Ports: Clk, reset (sync, active-high); CPOL, CPHA mode select; SCLK, SS,
// MOSI async bus inputs; MISOA, MISOB, MISO_OE bus outputs; txA_data,
// txB_data reply words; rx_data last command, rx_valid / frame_error
// one-cycle pulses; busy = frame in progress or awaiting SS release.
module aquatux_spi_slave
  import aquatux_spi_pkg::*;
#(
  parameter int unsigned WIDTH = SPI_WIDTH
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             CPOL,
  input  logic             CPHA,
  input  logic             SCLK,
  input  logic             SS,
  input  logic             MOSI,
  output logic             MISOA,
  output logic             MISOB,
  output logic             MISO_OE,
  input  logic [WIDTH-1:0] txA_data,
  input  logic [WIDTH-1:0] txB_data,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             frame_error,
  output logic             busy
);

  localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  logic sclk_s, ss_s, mosi_s;

  spi_sync2 #(.RESET_VAL(1'b0)) u_sync_sclk (.clk(Clk), .reset(reset), .d(SCLK), .q(sclk_s));
  spi_sync2 #(.RESET_VAL(1'b1)) u_sync_ss   (.clk(Clk), .reset(reset), .d(SS),   .q(ss_s));
  spi_sync2 #(.RESET_VAL(1'b0)) u_sync_mosi (.clk(Clk), .reset(reset), .d(MOSI), .q(mosi_s));

  spi_state_e       state_q, state_d;
  logic             sclk_dly_q, sclk_dly_d;
  logic             ss_dly_q, ss_dly_d;
  logic [1:0]       warm_q, warm_d;
  logic             armed_q, armed_d;
  logic             cpol_q, cpol_d;
  logic             cpha_q, cpha_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [WIDTH-1:0] txa_sr_q, txa_sr_d;
  logic [WIDTH-1:0] txb_sr_q, txb_sr_d;
  logic             misoa_q, misoa_d;
  logic             misob_q, misob_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_error_q, frame_error_d;

  logic      sclk_rise, sclk_fall, ss_fall, ss_rise;
  spi_edge_t edges;

  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;
  assign ss_fall   = ~ss_s & ss_dly_q;
  assign ss_rise   = ss_s & ~ss_dly_q;
  assign edges     = spi_edge_sel(cpol_q, cpha_q, sclk_rise, sclk_fall);

  always_comb begin
    state_d       = state_q;
    sclk_dly_d    = sclk_s;
    ss_dly_d      = ss_s;
    warm_d        = {warm_q[0], 1'b1};
    // A frame start is only accepted once SS has been seen high after the
    // synchronizer flushed its reset value; otherwise a reset with SS held
    // low would fabricate a falling edge.
    armed_d       = armed_q | (warm_q[1] & ss_s);
    cpol_d        = cpol_q;
    cpha_d        = cpha_q;
    cnt_d         = cnt_q;
    rx_sr_d       = rx_sr_q;
    txa_sr_d      = txa_sr_q;
    txb_sr_d      = txb_sr_q;
    misoa_d       = misoa_q;
    misob_d       = misob_q;
    rx_data_d     = rx_data_q;
    rx_valid_d    = 1'b0;
    frame_error_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        misoa_d = 1'b0;
        misob_d = 1'b0;
        if (ss_fall && armed_q) begin
          state_d = ACTIVE;
          cpol_d  = CPOL;
          cpha_d  = CPHA;
          cnt_d   = '0;
          rx_sr_d = '0;
          if (!CPHA) begin
            // MSB goes out immediately; the register holds the remaining bits.
            misoa_d  = txA_data[WIDTH-1];
            misob_d  = txB_data[WIDTH-1];
            txa_sr_d = {txA_data[WIDTH-2:0], 1'b0};
            txb_sr_d = {txB_data[WIDTH-2:0], 1'b0};
          end else begin
            txa_sr_d = txA_data;
            txb_sr_d = txB_data;
          end
        end
      end

      ACTIVE: begin
        if (edges.shift) begin
          misoa_d  = txa_sr_q[WIDTH-1];
          misob_d  = txb_sr_q[WIDTH-1];
          txa_sr_d = {txa_sr_q[WIDTH-2:0], 1'b0};
          txb_sr_d = {txb_sr_q[WIDTH-2:0], 1'b0};
        end
        if (edges.sample) begin
          rx_sr_d = {rx_sr_q[WIDTH-2:0], mosi_s};
          cnt_d   = cnt_q + CNT_W'(1);
        end
        if (edges.sample && (cnt_q == LAST_CNT)) begin
          // Final bit wins over a coincident SS release.
          rx_data_d  = {rx_sr_q[WIDTH-2:0], mosi_s};
          rx_valid_d = 1'b1;
          misoa_d    = 1'b0;
          misob_d    = 1'b0;
          state_d    = ss_rise ? IDLE : DONE;
        end else if (ss_rise) begin
          frame_error_d = 1'b1;
          misoa_d       = 1'b0;
          misob_d       = 1'b0;
          state_d       = IDLE;
        end
      end

      DONE: begin
        misoa_d = 1'b0;
        misob_d = 1'b0;
        if (ss_rise) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q       <= IDLE;
      sclk_dly_q    <= 1'b0;
      ss_dly_q      <= 1'b1;
      warm_q        <= '0;
      armed_q       <= 1'b0;
      cpol_q        <= 1'b0;
      cpha_q        <= 1'b0;
      cnt_q         <= '0;
      rx_sr_q       <= '0;
      txa_sr_q      <= '0;
      txb_sr_q      <= '0;
      misoa_q       <= 1'b0;
      misob_q       <= 1'b0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sclk_dly_q    <= sclk_dly_d;
      ss_dly_q      <= ss_dly_d;
      warm_q        <= warm_d;
      armed_q       <= armed_d;
      cpol_q        <= cpol_d;
      cpha_q        <= cpha_d;
      cnt_q         <= cnt_d;
      rx_sr_q       <= rx_sr_d;
      txa_sr_q      <= txa_sr_d;
      txb_sr_q      <= txb_sr_d;
      misoa_q       <= misoa_d;
      misob_q       <= misob_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign MISO_OE     = (state_q != IDLE);
  assign busy        = (state_q != IDLE);
  assign MISOA       = misoa_q & MISO_OE;
  assign MISOB       = misob_q & MISO_OE;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_aquatux_spi_slave.sv
// Bench for aquatux_spi_slave: acts as SPI master with SCLK = Clk/8, runs a
// table of directed frames followed by random frames, and compares against
// a frame-level model of the expected command word and MISO bit streams.
module tb_aquatux_spi_slave;

  localparam int W = 16;

  logic         Clk = 1'b0;
  logic         reset, CPOL, CPHA, SCLK, SS, MOSI;
  logic         MISOA, MISOB, MISO_OE;
  logic [W-1:0] txA_data, txB_data, rx_data;
  logic         rx_valid, frame_error, busy;

  always #5 Clk = ~Clk;

  aquatux_spi_slave #(.WIDTH(W)) dut (
    .Clk(Clk), .reset(reset), .CPOL(CPOL), .CPHA(CPHA),
    .SCLK(SCLK), .SS(SS), .MOSI(MOSI),
    .MISOA(MISOA), .MISOB(MISOB), .MISO_OE(MISO_OE),
    .txA_data(txA_data), .txB_data(txB_data),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_error(frame_error), .busy(busy)
  );

  int total = 0;
  int bad   = 0;
  int nvalid = 0;
  int nferr  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Pulse counting plus invariants sampled on every falling Clk edge.
  always @(negedge Clk) begin
    if (rx_valid === 1'b1) nvalid++;
    if (frame_error === 1'b1) nferr++;
    if (rx_valid === 1'b1 || frame_error === 1'b1)
      check("valid_ferr_excl", 32'(rx_valid & frame_error), 32'd0);
    if (MISO_OE === 1'b0)
      check("miso_zero_when_off", 32'({MISOA, MISOB}), 32'd0);
  end

  task automatic half();
    repeat (4) @(negedge Clk);
  endtask

  // Expected master-captured stream: bit i of the reply word per SCLK cycle
  // while the word lasts and no reset has cut the frame; zero otherwise.
  function automatic logic [31:0] exp_miso(input logic [W-1:0] tx, input int nclk, input int rst_at);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < nclk && i < W; i++)
      if (rst_at == 0 || i < rst_at) v[i] = tx[W-1-i];
    return v;
  endfunction

  task automatic run_frame(input logic cpol, input logic cpha, input logic [W-1:0] cmd,
                           input logic [W-1:0] txa, input logic [W-1:0] txb,
                           input int nclk, input int rst_at, input bit ss_last, input int gap,
                           output logic [31:0] cap_a, output logic [31:0] cap_b);
    cap_a = '0;
    cap_b = '0;
    if (SCLK !== cpol) begin
      SCLK = cpol;
      repeat (2) @(negedge Clk);
    end
    CPOL = cpol; CPHA = cpha; txA_data = txa; txB_data = txb;
    MOSI = cpha ? 1'b0 : cmd[W-1];
    SS = 1'b0;
    half();
    for (int i = 0; i < nclk; i++) begin
      bit b;
      b = (i < W) ? cmd[W-1-i] : 1'b0;
      if (i == 1) begin
        // Changes mid-frame must not affect this frame.
        txA_data = ~txa; txB_data = ~txb; CPOL = ~cpol; CPHA = ~cpha;
      end
      SCLK = ~cpol;
      if (cpha) MOSI = b;
      else begin cap_a[i] = MISOA; cap_b[i] = MISOB; end
      half();
      SCLK = cpol;
      if (cpha) begin cap_a[i] = MISOA; cap_b[i] = MISOB; end
      else MOSI = (i + 1 < W) ? cmd[W-2-i] : 1'b0;
      if (i == 0) check("oe_in_frame", 32'(MISO_OE), 32'd1);
      if (!(ss_last && i == nclk - 1)) half();
      if (rst_at != 0 && i == rst_at - 1) begin
        reset = 1'b1;
        repeat (3) @(negedge Clk);
        reset = 1'b0;
      end
    end
    SS = 1'b1;
    repeat (4) @(negedge Clk);
    check("busy_after_ss", 32'(busy), 32'd0);
    check("oe_after_ss", 32'(MISO_OE), 32'd0);
    repeat (gap - 4) @(negedge Clk);
  endtask

  typedef struct {
    logic         cpol;
    logic         cpha;
    logic [W-1:0] cmd;
    logic [W-1:0] txa;
    logic [W-1:0] txb;
    int           nclk;
    int           rst_at;
    bit           ss_last;
    int           gap;
    logic [W-1:0] exp_rx;
    int           exp_v;
    int           exp_f;
  } vec_t;

  vec_t tbl[9];

  initial begin
    logic [31:0] ca, cb;
    logic [W-1:0] model_rx;
    int v0, f0;

    tbl[0] = '{1'b0, 1'b0, 16'hA5C3, 16'h1234, 16'hBEEF, 16, 0, 1'b0, 8, 16'hA5C3, 1, 0};
    tbl[1] = '{1'b1, 1'b1, 16'h8001, 16'hFFFF, 16'h0000, 16, 0, 1'b0, 8, 16'h8001, 1, 0};
    tbl[2] = '{1'b0, 1'b0, 16'h3333, 16'h5555, 16'hAAAA, 10, 0, 1'b0, 8, 16'h8001, 0, 1};
    tbl[3] = '{1'b0, 1'b0, 16'h5A5A, 16'hC3C3, 16'h0FF0, 18, 0, 1'b0, 8, 16'h5A5A, 1, 0};
    tbl[4] = '{1'b0, 1'b0, 16'hFFFF, 16'h9999, 16'h6666, 16, 5, 1'b0, 8, 16'h0000, 0, 0};
    tbl[5] = '{1'b0, 1'b0, 16'h0F0F, 16'h7E81, 16'h1818, 16, 0, 1'b0, 4, 16'h0F0F, 1, 0};
    tbl[6] = '{1'b0, 1'b1, 16'hC0DE, 16'hF00D, 16'h4321, 16, 0, 1'b0, 8, 16'hC0DE, 1, 0};
    tbl[7] = '{1'b1, 1'b0, 16'h1357, 16'h2468, 16'hFEDC, 16, 0, 1'b0, 8, 16'h1357, 1, 0};
    tbl[8] = '{1'b0, 1'b1, 16'h2468, 16'h0001, 16'h8000, 16, 0, 1'b1, 8, 16'h2468, 1, 0};

    reset = 1'b1; SS = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
    CPOL = 1'b0; CPHA = 1'b0; txA_data = '0; txB_data = '0;
    repeat (3) @(negedge Clk);
    check("rst_misoa", 32'(MISOA), 32'd0);
    check("rst_misob", 32'(MISOB), 32'd0);
    check("rst_oe", 32'(MISO_OE), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_ferr", 32'(frame_error), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    repeat (6) @(negedge Clk);

    for (int k = 0; k < 9; k++) begin
      v0 = nvalid; f0 = nferr;
      run_frame(tbl[k].cpol, tbl[k].cpha, tbl[k].cmd, tbl[k].txa, tbl[k].txb,
                tbl[k].nclk, tbl[k].rst_at, tbl[k].ss_last, tbl[k].gap, ca, cb);
      check($sformatf("tbl%0d_rx_data", k), 32'(rx_data), 32'(tbl[k].exp_rx));
      check($sformatf("tbl%0d_nvalid", k), 32'(nvalid - v0), 32'(tbl[k].exp_v));
      check($sformatf("tbl%0d_nferr", k), 32'(nferr - f0), 32'(tbl[k].exp_f));
      check($sformatf("tbl%0d_misoa", k), ca, exp_miso(tbl[k].txa, tbl[k].nclk, tbl[k].rst_at));
      check($sformatf("tbl%0d_misob", k), cb, exp_miso(tbl[k].txb, tbl[k].nclk, tbl[k].rst_at));
    end

    model_rx = tbl[8].exp_rx;
    for (int k = 0; k < 24; k++) begin
      logic         cpol, cpha;
      logic [W-1:0] cmd, txa, txb;
      int           nclk;
      bit           ss_last;
      cpol = 1'($urandom % 2);
      cpha = 1'($urandom % 2);
      cmd  = W'($urandom);
      txa  = W'($urandom);
      txb  = W'($urandom);
      nclk = ($urandom % 4 == 0) ? int'($urandom_range(1, 20)) : W;
      ss_last = cpha && (nclk == W) && ($urandom % 2 == 1);
      v0 = nvalid; f0 = nferr;
      run_frame(cpol, cpha, cmd, txa, txb, nclk, 0, ss_last, 8, ca, cb);
      if (nclk >= W) model_rx = cmd;
      check($sformatf("rnd%0d_rx_data", k), 32'(rx_data), 32'(model_rx));
      check($sformatf("rnd%0d_nvalid", k), 32'(nvalid - v0), (nclk >= W) ? 32'd1 : 32'd0);
      check($sformatf("rnd%0d_nferr", k), 32'(nferr - f0), (nclk >= W) ? 32'd0 : 32'd1);
      check($sformatf("rnd%0d_misoa", k), ca, exp_miso(txa, nclk, 0));
      check($sformatf("rnd%0d_misob", k), cb, exp_miso(txb, nclk, 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
